// File: rtl/tff_bank_sequencer.sv
// Sequencer for an external bank of toggle flip-flops used as a programmable
// up/down counter. Run settings are captured when a start is accepted; the
// bank is then preloaded or cleared, counted toward the limit, and a one-cycle
// done pulse is issued on the match.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for start; bank untouched
// S_LOAD  | one cycle of toggles that turns the bank into the preload value
// S_CLEAR | one cycle of bank_reset so the bank starts from zero
// S_RUN   | count one step per cycle until q_vec matches the limit
// S_DONE  | one-cycle done pulse; bank holds the limit
module tff_bank_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    input  logic [WIDTH-1:0] q_vec,
    output logic [WIDTH-1:0] t_vec,
    output logic             bank_reset,
    output logic             busy,
    output logic             done,
    output logic             tc
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CLEAR = 3'd2,
        S_RUN   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_up;
    logic             r_load;
    logic [WIDTH-1:0] r_limit;
    logic [WIDTH-1:0] r_val;

    logic [WIDTH-1:0] w_count_t;
    logic             w_chain;
    logic             w_match;
    logic             w_accept;

    assign w_match  = (q_vec == r_limit);
    assign w_accept = (r_state == S_IDLE) && start;

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Capture run settings on the accepted start; later input changes are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_up    <= 1'b0;
            r_load  <= 1'b0;
            r_limit <= '0;
            r_val   <= '0;
        end else if (w_accept) begin
            r_up    <= up_dn;
            r_load  <= load;
            r_limit <= limit;
            r_val   <= load_val;
        end
    end

    // Ripple toggle pattern: bit i toggles when all lower bits are 1 (up) or 0 (down).
    always_comb begin
        w_count_t = '0;
        w_chain   = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            w_count_t[i] = w_chain;
            w_chain      = w_chain & (r_up ? q_vec[i] : ~q_vec[i]);
        end
    end

    // Next-state decode; stop wins over a limit match in RUN.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = load ? S_LOAD : S_CLEAR;
                end
            end
            S_LOAD, S_CLEAR: begin
                w_next = stop ? S_IDLE : S_RUN;
            end
            S_RUN: begin
                if (stop) begin
                    w_next = S_IDLE;
                end else if (w_match) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Output decode from the current state and the live bank value.
    always_comb begin
        t_vec      = '0;
        bank_reset = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        tc         = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
            end
            S_LOAD: begin
                t_vec = q_vec ^ r_val;
            end
            S_CLEAR: begin
                bank_reset = 1'b1;
            end
            S_RUN: begin
                tc = w_match;
                if (!stop && !w_match) begin
                    t_vec = w_count_t;
                end
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_tff_bank_sequencer.sv
module tb_tff_bank_sequencer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         stop;
    logic         up_dn;
    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] limit;
    logic [W-1:0] q_vec = '0;
    logic [W-1:0] t_vec;
    logic         bank_reset;
    logic         busy;
    logic         done;
    logic         tc;

    int checks   = 0;
    int failures = 0;

    tff_bank_sequencer #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .up_dn      (up_dn),
        .load       (load),
        .load_val   (load_val),
        .limit      (limit),
        .q_vec      (q_vec),
        .t_vec      (t_vec),
        .bank_reset (bank_reset),
        .busy       (busy),
        .done       (done),
        .tc         (tc)
    );

    always #5 clk = ~clk;

    // Toggle flip-flop bank closing the loop: synchronous clear, else toggle where t=1.
    always_ff @(posedge clk) begin
        if (bank_reset) q_vec <= '0;
        else            q_vec <= q_vec ^ t_vec;
    end

    typedef struct {
        logic         ld;
        logic         up;
        logic [W-1:0] val;
        logic [W-1:0] lim;
        int           lat;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic accept_start(input logic ld, input logic up, input logic [W-1:0] val,
                                input logic [W-1:0] lim);
        @(negedge clk);
        start = 1'b1; load = ld; up_dn = up; load_val = val; limit = lim;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_q(input logic [W-1:0] target);
        int n;
        n = 0;
        while (q_vec != target && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("wait_q_timeout", (q_vec == target), 1);
    endtask

    task automatic do_run(input int idx);
        vec_t         v;
        logic [W-1:0] exp_q;
        logic [W-1:0] exp_t;
        int           cnt;
        logic         seen;
        v = vecs[idx];
        accept_start(v.ld, v.up, v.val, v.lim);
        // Setup cycle: also try a conflicting start and scramble the run inputs.
        chk("setup_busy", busy, 1);
        if (v.ld) begin
            chk("load_t", t_vec, q_vec ^ v.val);
            chk("load_bank_reset", bank_reset, 0);
        end else begin
            chk("clear_bank_reset", bank_reset, 1);
            chk("clear_t", t_vec, 0);
        end
        start = 1'b1; load = ~v.ld; up_dn = ~v.up; load_val = ~v.val; limit = ~v.lim;
        exp_q = v.ld ? v.val : '0;
        cnt   = 0;
        seen  = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            start = 1'b0;
            cnt++;
            if (done) begin
                seen = 1'b1;
                break;
            end
            chk("run_busy", busy, 1);
            chk("run_q", q_vec, exp_q);
            if (exp_q == v.lim) begin
                chk("run_tc_hit", tc, 1);
                chk("run_t_hit", t_vec, 0);
            end else begin
                exp_t = v.up ? (exp_q ^ (exp_q + 4'd1)) : (exp_q ^ (exp_q - 4'd1));
                chk("run_tc", tc, 0);
                chk("run_t", t_vec, exp_t);
                exp_q = v.up ? exp_q + 4'd1 : exp_q - 4'd1;
            end
        end
        chk("done_seen", seen, 1);
        chk("done_latency", cnt, v.lat);
        chk("done_t", t_vec, 0);
        @(negedge clk);
        chk("post_done", done, 0);
        chk("post_busy", busy, 0);
        chk("post_q", q_vec, v.lim);
    endtask

    initial begin
        //           ld    up    val   lim   latency (1 setup + N + 1 match)
        vecs[0] = '{1'b0, 1'b1, 4'h0, 4'h5, 7};
        vecs[1] = '{1'b1, 1'b1, 4'hE, 4'h1, 5};
        vecs[2] = '{1'b1, 1'b0, 4'h3, 4'hD, 8};
        vecs[3] = '{1'b1, 1'b1, 4'h9, 4'h9, 2};
        vecs[4] = '{1'b0, 1'b0, 4'h7, 4'hE, 4};

        reset = 1'b1; start = 1'b0; stop = 1'b0; up_dn = 1'b0; load = 1'b0;
        load_val = '0; limit = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_bank_reset", bank_reset, 0);
        chk("rst_t", t_vec, 0);
        chk("rst_tc", tc, 0);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) do_run(i);

        // Stop mid-count at q=6: bank frozen, no done.
        accept_start(1'b0, 1'b1, 4'h0, 4'hF);
        wait_q(4'h6);
        stop = 1'b1;
        #1;
        chk("stop_t", t_vec, 0);
        @(negedge clk);
        stop = 1'b0;
        chk("stop_busy", busy, 0);
        chk("stop_done", done, 0);
        repeat (3) begin
            @(negedge clk);
            chk("stop_frozen_q", q_vec, 6);
            chk("stop_no_done", done, 0);
        end

        // Stop coinciding with a limit match on the first RUN cycle.
        accept_start(1'b1, 1'b1, 4'h3, 4'h3);
        @(negedge clk);
        chk("match_tc", tc, 1);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("stopmatch_busy", busy, 0);
        chk("stopmatch_done", done, 0);
        @(negedge clk);
        chk("stopmatch_done2", done, 0);

        // Synchronous reset in the middle of a run.
        accept_start(1'b0, 1'b1, 4'h0, 4'hF);
        wait_q(4'h3);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_t", t_vec, 0);
        chk("midrst_bank_reset", bank_reset, 0);
        chk("midrst_done", done, 0);
        chk("midrst_tc", tc, 0);
        reset = 1'b0;

        // Normal run after the reset still works.
        do_run(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
